// File: rtl/stupidrv_dmem_bridge_if.sv
// Signal bundle between the core data port, the bridge and the valid/ready bus.
// The slave modport is the bridge's view; master is the view of the surrounding core/bus.
interface stupidrv_dmem_bridge_if;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_stall;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport slave (
        input  dmem_valid, dmem_addr, dmem_wstrb, dmem_wdata,
        input  bus_ready, bus_rvalid, bus_rdata,
        output dmem_rdata, dmem_stall,
        output bus_valid, bus_addr, bus_wstrb, bus_wdata, bus_err
    );

    modport master (
        output dmem_valid, dmem_addr, dmem_wstrb, dmem_wdata,
        output bus_ready, bus_rvalid, bus_rdata,
        input  dmem_rdata, dmem_stall,
        input  bus_valid, bus_addr, bus_wstrb, bus_wdata, bus_err
    );
endinterface

// File: rtl/stupidrv_dmem_bridge.sv
// Bridges the core's zero-wait data port onto a variable-latency valid/ready bus,
// freezing the core via dmem_stall until each request completes or times out.
module stupidrv_dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    stupidrv_dmem_bridge_if.slave  bus_io
);
    localparam int unsigned RAW_W = $clog2(64'(TIMEOUT_CYCLES) + 64'd1);
    localparam int unsigned CNT_W = (RAW_W < 8) ? 8 : ((RAW_W > 32) ? 32 : RAW_W);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             timeout_hit;
    logic             is_write;

    assign is_write    = (wstrb_q != 4'd0);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_VAL) &&
                         ((state_q == REQ) || (state_q == RESP));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus_io.dmem_valid) begin
                    addr_d  = bus_io.dmem_addr;
                    wstrb_d = bus_io.dmem_wstrb;
                    wdata_d = bus_io.dmem_wdata;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (timeout_hit) begin
                    err_d   = 1'b1;
                    if (!is_write) rdata_d = 32'h0;
                    state_d = DONE;
                end else if (bus_io.bus_ready) begin
                    state_d = is_write ? DONE : RESP;
                end
            end
            RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response arriving on the deadline cycle is still accepted.
                if (bus_io.bus_rvalid) begin
                    rdata_d = bus_io.bus_rdata;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= 32'h0;
            wstrb_q <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        bus_io.bus_valid  = (state_q == REQ) && !timeout_hit;
        bus_io.dmem_stall = 1'b1;
        case (state_q)
            IDLE:    bus_io.dmem_stall = bus_io.dmem_valid;
            DONE:    bus_io.dmem_stall = 1'b0;
            default: bus_io.dmem_stall = 1'b1;
        endcase
    end

    assign bus_io.bus_addr   = addr_q;
    assign bus_io.bus_wstrb  = wstrb_q;
    assign bus_io.bus_wdata  = wdata_q;
    assign bus_io.dmem_rdata = rdata_q;
    assign bus_io.bus_err    = err_q;
endmodule

// File: tb/tb_stupidrv_dmem_bridge.sv
// Self-checking bench for stupidrv_dmem_bridge: directed table, corner-case sequences,
// and randomized transactions checked against a transaction-level latency/data model.
module tb_stupidrv_dmem_bridge;
    localparam int TO = 4;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   hs_count;

    stupidrv_dmem_bridge_if bif ();

    stupidrv_dmem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus_io (bif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bif.bus_valid && bif.bus_ready) hs_count <= hs_count + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          w;
        int          r;
        int          exp_lat;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive_idle_inputs();
        bif.dmem_valid = 1'b0;
        bif.dmem_addr  = 32'h0;
        bif.dmem_wstrb = 4'h0;
        bif.dmem_wdata = 32'h0;
        bif.bus_ready  = 1'b0;
        bif.bus_rvalid = 1'b0;
        bif.bus_rdata  = 32'h0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
            drive_idle_inputs();
            @(negedge clock);
            chk("idle_stall", {31'h0, bif.dmem_stall}, 32'h0);
        end
    endtask

    // One core request; bus grants ready after w wait cycles, read data r cycles after handshake.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [3:0] strb,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int w, input int r, input bit early_rv, output int lat);
        bit hs_sched;
        lat = -1;
        hs_sched = (w < TO);
        for (int i = 0; i <= 12; i++) begin
            @(posedge clock); #1;
            bif.dmem_valid = 1'b1;
            bif.dmem_addr  = addr;
            bif.dmem_wstrb = wr ? strb : 4'h0;
            bif.dmem_wdata = wd;
            bif.bus_ready  = hs_sched && (i == 1 + w);
            bif.bus_rvalid = (!wr && hs_sched && (i == 2 + w + r)) ||
                             (early_rv && hs_sched && (i == 1 + w));
            bif.bus_rdata  = (i == 2 + w + r) ? rd : 32'hBAD0BAD0;
            @(negedge clock);
            if (i >= 1 && i <= 1 + w && i <= TO) begin
                chk("req_valid", {31'h0, bif.bus_valid}, 32'h1);
                chk("req_addr", bif.bus_addr, addr);
                chk("req_wstrb", {28'h0, bif.bus_wstrb}, wr ? {28'h0, strb} : 32'h0);
                chk("req_wdata", bif.bus_wdata, wd);
            end
            if (w >= TO && i == TO + 1)
                chk("timeout_valid_drop", {31'h0, bif.bus_valid}, 32'h0);
            if (!bif.dmem_stall) begin
                lat = i;
                break;
            end
        end
    endtask

    int          lat;
    int          hs_before;
    logic [31:0] m_rdata;
    bit          m_err;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        hs_count = 0;
        reset    = 1'b1;
        drive_idle_inputs();

        vecs[0] = '{1'b0, 32'h100, 4'h0, 32'h0,    32'hDEADBEEF, 0, 0, 3, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b1, 32'h200, 4'h3, 32'h1234, 32'h0,        3, 0, 5, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b0, 32'h104, 4'h0, 32'h0,    32'hCAFEF00D, 1, 1, 5, 32'hCAFEF00D, 1'b0};
        vecs[3] = '{1'b1, 32'h300, 4'hF, 32'h5555, 32'h0,        0, 0, 2, 32'hCAFEF00D, 1'b0};
        vecs[4] = '{1'b0, 32'h108, 4'h0, 32'h0,    32'h0BADC0DE, 2, 0, 5, 32'h0BADC0DE, 1'b0};
        vecs[5] = '{1'b0, 32'h10C, 4'h0, 32'h0,    32'h77777777, 7, 0, 6, 32'h00000000, 1'b1};

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_bus_valid", {31'h0, bif.bus_valid}, 32'h0);
        chk("rst_bus_addr", bif.bus_addr, 32'h0);
        chk("rst_bus_wstrb", {28'h0, bif.bus_wstrb}, 32'h0);
        chk("rst_bus_wdata", bif.bus_wdata, 32'h0);
        chk("rst_rdata", bif.dmem_rdata, 32'h0);
        chk("rst_err", {31'h0, bif.bus_err}, 32'h0);
        chk("rst_stall", {31'h0, bif.dmem_stall}, 32'h0);
        reset = 1'b0;
        idle(1);

        // Directed table
        for (int v = 0; v < 6; v++) begin
            run_txn(vecs[v].wr, vecs[v].addr, vecs[v].strb, vecs[v].wdata, vecs[v].rdata,
                    vecs[v].w, vecs[v].r, 1'b0, lat);
            chk("vec_latency", lat, vecs[v].exp_lat);
            idle(1);
            chk("vec_rdata", bif.dmem_rdata, vecs[v].exp_rdata);
            chk("vec_err", {31'h0, bif.bus_err}, {31'h0, vecs[v].exp_err});
            $display("[TB] vec %0d wr=%0d addr=%h lat=%0d rdata=%h err=%0d",
                     v, vecs[v].wr, vecs[v].addr, lat, bif.dmem_rdata, bif.bus_err);
        end

        // Error flag is sticky
        idle(10);
        chk("err_sticky", {31'h0, bif.bus_err}, 32'h1);

        // Back-to-back read then store in the cycle after DONE
        hs_before = hs_count;
        run_txn(1'b0, 32'h400, 4'h0, 32'h0, 32'h13579BDF, 0, 0, 1'b0, lat);
        chk("b2b_read_lat", lat, 3);
        run_txn(1'b1, 32'h404, 4'hC, 32'hA5A5A5A5, 32'h0, 0, 0, 1'b0, lat);
        chk("b2b_write_lat", lat, 2);
        idle(1);
        chk("b2b_handshakes", hs_count - hs_before, 2);
        chk("b2b_rdata", bif.dmem_rdata, 32'h13579BDF);
        $display("[TB] back-to-back handshakes=%0d rdata=%h", hs_count - hs_before, bif.dmem_rdata);

        // rvalid coincident with handshake is ignored
        run_txn(1'b0, 32'h408, 4'h0, 32'h0, 32'h2468ACE0, 0, 1, 1'b1, lat);
        chk("early_rv_lat", lat, 4);
        idle(1);
        chk("early_rv_rdata", bif.dmem_rdata, 32'h2468ACE0);
        $display("[TB] early rvalid lat=%0d rdata=%h", lat, bif.dmem_rdata);

        // Reset asserted while waiting in RESP, then stale response
        @(posedge clock); #1;
        bif.dmem_valid = 1'b1; bif.dmem_addr = 32'h500; bif.dmem_wstrb = 4'h0;
        @(posedge clock); #1;
        bif.bus_ready = 1'b1;
        @(posedge clock); #1;
        bif.bus_ready = 1'b0;
        @(negedge clock);
        chk("resp_stall", {31'h0, bif.dmem_stall}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_valid", {31'h0, bif.bus_valid}, 32'h0);
        bif.dmem_valid = 1'b0;
        #1;
        chk("rst_mid_stall", {31'h0, bif.dmem_stall}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'hFFFFFFFF;
        @(negedge clock);
        chk("stale_stall", {31'h0, bif.dmem_stall}, 32'h0);
        @(posedge clock); #1;
        bif.bus_rvalid = 1'b0;
        @(negedge clock);
        chk("stale_rdata", bif.dmem_rdata, 32'h0);
        chk("rst_clears_err", {31'h0, bif.bus_err}, 32'h0);
        $display("[TB] reset in RESP rdata=%h err=%0d", bif.dmem_rdata, bif.bus_err);

        // Stale rvalid in IDLE with no request
        @(posedge clock); #1;
        bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'h55AA55AA;
        @(negedge clock);
        chk("idle_rv_stall", {31'h0, bif.dmem_stall}, 32'h0);
        idle(1);
        chk("idle_rv_rdata", bif.dmem_rdata, 32'h0);
        run_txn(1'b0, 32'h600, 4'h0, 32'h0, 32'h0F0F0F0F, 0, 0, 1'b0, lat);
        chk("idle_rv_next_lat", lat, 3);
        idle(1);
        chk("idle_rv_next_rdata", bif.dmem_rdata, 32'h0F0F0F0F);

        // Randomized transactions against a transaction-level model
        m_rdata = 32'h0F0F0F0F;
        m_err   = 1'b0;
        for (int k = 0; k < 80; k++) begin
            bit          wr;
            bit          tmo;
            logic [31:0] addr;
            logic [31:0] wd;
            logic [31:0] rd;
            logic [3:0]  strb;
            int          w;
            int          r;
            int          exp_lat;
            int          gap;
            wr   = 1'($urandom_range(0, 1));
            addr = $urandom & 32'hFFFF_FFFC;
            wd   = $urandom;
            rd   = $urandom;
            strb = 4'($urandom_range(1, 15));
            w    = $urandom_range(0, 5);
            r    = $urandom_range(0, 4);
            if (!wr && w < TO && (w + 1 + r) == TO) r = r + 1;
            // Deadline: TO cycles after the request leaves IDLE, unless the bus finished first.
            tmo = (w >= TO) || (!wr && (w + 1 + r) > TO);
            if (tmo)     exp_lat = TO + 2;
            else if (wr) exp_lat = 2 + w;
            else         exp_lat = 3 + w + r;
            if (!wr) m_rdata = tmo ? 32'h0 : rd;
            if (tmo) m_err = 1'b1;
            run_txn(wr, addr, strb, wd, rd, w, r, 1'b0, lat);
            chk("rnd_latency", lat, exp_lat);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                idle(gap);
                chk("rnd_rdata", bif.dmem_rdata, m_rdata);
                chk("rnd_err", {31'h0, bif.bus_err}, {31'h0, m_err});
            end
            $display("[TB] rnd %0d wr=%0d w=%0d r=%0d lat=%0d exp_lat=%0d rdata=%h",
                     k, wr, w, r, lat, exp_lat, bif.dmem_rdata);
        end
        idle(1);
        chk("rnd_final_rdata", bif.dmem_rdata, m_rdata);
        chk("rnd_final_err", {31'h0, bif.bus_err}, {31'h0, m_err});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
